// File: rtl/shift40_readout_ctrl.sv
// shift40_readout_ctrl
// Sequencer for the 41-bit serial TDC readout chain. It generates sclk/sen,
// shifts sda in MSB-first, checks the marker bit and presents {addr, data}
// on a valid/ready port. It supports single, counted or continuous readout.
// Frame layout: bit0 = marker, bits[32:1] = data, bits[40:33] = addr.
// Optional address filter: define SHIFT40_ADDR_FILTER_EN to add the
// addr_match/addr_mask inputs.
`timescale 1ns/1ps
module shift40_readout_ctrl #(
    parameter int FRAME_BITS = 41,
    parameter int CLK_DIV    = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] nframes,
    input  logic             sda,
    output logic             sclk,
    output logic             sen,
    output logic             busy,
    output logic [31:0]      out_data,
    output logic [7:0]       out_addr,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT40_ADDR_FILTER_EN
    input  logic [7:0]       addr_match,
    input  logic [7:0]       addr_mask,
`endif
    output logic             marker_err,
    output logic [CNT_W-1:0] good_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

    state_t                state, state_d;
    logic [FRAME_BITS-1:0] shreg;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      remaining;
    logic                  continuous;
    logic                  stop_seen;

    logic div_last;
    logic shift_done;
    logic addr_ok;
    logic deliver;
    logic last_frame;
    logic frame_done;

    assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
    // The frame ends on the fall that follows the last rising edge.
    assign shift_done = div_last && sclk && (bit_cnt == BIT_W'(FRAME_BITS));

`ifdef SHIFT40_ADDR_FILTER_EN
    assign addr_ok = ((shreg[40:33] & addr_mask) == (addr_match & addr_mask));
`else
    assign addr_ok = 1'b1;
`endif

    assign deliver    = shreg[0] && addr_ok;
    // A stop raised on the exit cycle itself still ends the readout.
    assign last_frame = stop_seen || stop || (!continuous && (remaining == CNT_W'(1)));
    // Exit points that hand over to the next-frame decision.
    assign frame_done = ((state == CHECK) && !deliver) || ((state == HOLD) && out_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic, including the next-frame decision at CHECK/HOLD exit.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = CHECK;
            CHECK:   if (deliver) state_d = HOLD;
                     else state_d = last_frame ? IDLE : SHIFT;
            HOLD:    if (out_ready) state_d = last_frame ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the chain is only enabled while shifting.
    always_comb begin
        sen  = (state == SHIFT);
        busy = (state != IDLE);
    end

    // Datapath: clock divider, shift register, frame counters and output port.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            remaining  <= '0;
            continuous <= 1'b0;
            stop_seen  <= 1'b0;
            sclk       <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            marker_err <= 1'b0;
            good_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            marker_err <= 1'b0;

            // Stop is sticky for the whole readout; start+stop reads one frame.
            if (state == IDLE) begin
                stop_seen <= start && stop;
            end else begin
                stop_seen <= stop_seen || stop;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        remaining  <= nframes;
                        continuous <= (nframes == '0);
                        good_cnt   <= '0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        sclk       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            // sda is sampled on the same edge that raises sclk.
                            sclk    <= 1'b1;
                            shreg   <= {shreg[FRAME_BITS-2:0], sda};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end else begin
                            sclk <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CHECK: begin
                    if (deliver) begin
                        out_data  <= shreg[32:1];
                        out_addr  <= shreg[40:33];
                        out_valid <= 1'b1;
                        good_cnt  <= good_cnt + CNT_W'(1);
                    end else if (!shreg[0]) begin
                        marker_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Every frame, delivered or dropped, counts against nframes.
            if (frame_done) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                if (!last_frame && !continuous) begin
                    remaining <= remaining - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/shift40_readout_ctrl.md
Name: shift40_readout_ctrl

Overview:
Sequencer for the 41-bit serial TDC readout chain (1 marker bit, 32 data bits, 8 address bits). It generates the divided serial clock and enable for the chain and shifts in `sda` with the same bit order as the chain. It checks the marker bit at frame end and presents {addr, data} on a valid/ready output port. It sits between the TDC serial readout and the downstream readout FIFO/packer, and supports single, counted or continuous frame readout.

Parameters:
- FRAME_BITS, 41: serial bits per frame. Layout is fixed: bit0 = marker `t`, bits[32:1] = data, bits[40:33] = addr.
- CLK_DIV, 4: `clk` cycles per `sclk` half-period; must be >= 1.
- CNT_W, 16: width of `nframes` and `good_cnt`.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin readout; sampled only in IDLE
- stop  in  1  request halt; takes effect at the next frame boundary
- nframes  in  CNT_W  frames to read; 0 = continuous until `stop`; latched on accepted `start`
- sda  in  1  serial data from the chain
- sclk  out  1  serial shift clock to the chain
- sen  out  1  chain enable
- busy  out  1  high in every state except IDLE
- out_data  out  32  frame data bits[32:1]
- out_addr  out  8  frame address bits[40:33]
- out_valid  out  1  frame available
- out_ready  in  1  downstream accept
- marker_err  out  1  one-cycle pulse: frame dropped because marker = 0
- good_cnt  out  CNT_W  count of delivered frames; wraps; cleared on accepted `start`

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal shift register, `div_cnt`, `bit_cnt` and remaining-frame count = 0. Reset mid-frame aborts immediately: `sclk` goes to 0 on the next edge and the partial frame is discarded.
- States: IDLE, SHIFT, CHECK, HOLD.
- IDLE:
  - `start` = 1 → latch `nframes`, clear `good_cnt`, go to SHIFT with `sclk` = 0, `div_cnt` = 0, `bit_cnt` = 0.
  - `stop` is ignored.
- SHIFT:
  - `sen` = 1. `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - When `div_cnt` = CLK_DIV-1 and `sclk` = 0: `sclk` <= 1, `shreg` <= {`shreg`[39:0], `sda`}, `bit_cnt` + 1. `sda` is sampled on the same `clk` edge that raises `sclk`.
  - When `div_cnt` = CLK_DIV-1 and `sclk` = 1: `sclk` <= 0. If `bit_cnt` = FRAME_BITS, go to CHECK.
  - SHIFT therefore lasts exactly FRAME_BITS*2*CLK_DIV cycles. `sen` drops on the same edge as the final `sclk` fall.
  - The first bit shifted in ends at bit40; the last bit shifted in is the marker (bit0).
- CHECK (1 cycle):
  - `shreg`[0] = 1 → load `out_data` = `shreg`[32:1], `out_addr` = `shreg`[40:33]; set `out_valid` = 1; increment `good_cnt`; go to HOLD.
  - `shreg`[0] = 0 → pulse `marker_err`; no output; go to NEXT decision.
  - Either way, the frame counts against `nframes`.
- HOLD:
  - `out_valid` stays high and `out_data`/`out_addr` stay stable until `out_valid` && `out_ready`.
  - On that cycle `out_valid` <= 0, then NEXT decision. `sclk` stays 0 and `sen` stays 0 while stalled (backpressure stops the chain).
- NEXT decision (evaluated combinationally at the exit of CHECK or HOLD):
  - `stop` seen since frame start, or remaining = 1 with `nframes` ≠ 0 → IDLE.
  - Otherwise decrement remaining (if counted) and go to SHIFT with fresh `div_cnt` and `bit_cnt`.
  - `stop` is sticky from assertion during SHIFT/CHECK/HOLD until IDLE.
  - `start` and `stop` asserted together in IDLE → one frame is read, then IDLE.
- `good_cnt` wraps from 2^CNT_W-1 to 0 without a flag.
- Continuous mode with `out_ready` tied high: inter-frame gap = CHECK + HOLD handshake = 2 cycles.

Optional Feature:
- Macro: SHIFT40_ADDR_FILTER_EN.
- With the macro:
  - Adds inputs `addr_match` [7:0] and `addr_mask` [7:0].
  - In CHECK, a frame with a good marker and (`shreg`[40:33] & `addr_mask`) ≠ (`addr_match` & `addr_mask`) is dropped silently: no `out_valid`, no `good_cnt` increment, no `marker_err`. It still counts against `nframes`.
  - `addr_mask` = 0 passes every frame.
- Without the macro: the ports are absent and every frame with marker = 1 is delivered.

Test Plan:
1. CLK_DIV=4, `nframes`=1, `sda` drives addr 0x5A, data 0xDEADBEEF, marker 1 → `out_addr`=0x5A, `out_data`=0xDEADBEEF, `out_valid` rises 328+1 cycles after `start`, `good_cnt`=1; then `busy`=0.
2. Marker bit driven 0, `nframes`=2 with the second frame good → exactly one `marker_err` pulse, one `out_valid`, `good_cnt`=1.
3. `nframes`=0, `out_ready` low for 50 cycles on the first frame → `sclk`/`sen` held 0 and outputs stable throughout; after `out_ready`, the next frame starts; `stop` mid-frame 3 → frame 3 is delivered, then IDLE.
4. Assert `rst` at bit 20 of a frame → the next cycle shows `sclk`=0, `busy`=0, `out_valid`=0; a new `start` reads a clean frame correctly.
5. CLK_DIV=1, continuous mode, `out_ready`=1 → `sclk` period is 2 cycles, 82 cycles per frame + 2-cycle gap, 4 consecutive frames delivered in order.
6. (SHIFT40_ADDR_FILTER_EN) `addr_mask`=0xF0, `addr_match`=0x30; frames with addr 0x35 and 0x45 → only 0x35 delivered, `good_cnt`=1, no `marker_err`.
